reg_access_master: RTL and testbench
====================================

Name: reg_access_master

Overview:
Initiator side of the register-file port set (write port plus two asynchronous read ports). Takes host commands over a valid/ready channel and drives the register file's address, write-enable and write-data pins. Returns read data over a valid/ready response channel. Used for debug, test-bench loading and post-run register dumps, alongside the CPU datapath.

Parameters:
DATA_WIDTH, 32, register width.
ADDR_WIDTH, 5, register index width; register count N = 2**ADDR_WIDTH; must be >= 1.

Ports:
clk  in  1  clock.
rst  in  1  synchronous, active-high reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  command accepted when high with cmd_valid.
cmd_op  in  2  00 read, 01 write, 10 dump, 11 clear (optional).
cmd_addr  in  ADDR_WIDTH  register index for read/write.
cmd_wdata  in  DATA_WIDTH  write data.
rsp_valid  out  1  response present.
rsp_ready  in  1  response consumed when high with rsp_valid.
rsp_addr  out  ADDR_WIDTH  index of returned register.
rsp_data  out  DATA_WIDTH  returned value.
rsp_last  out  1  final response of a command.
rf_waddr  out  ADDR_WIDTH  to register file write address.
rf_wen  out  1  to register file write enable.
rf_wdata  out  DATA_WIDTH  to register file write data.
rf_raddr1  out  ADDR_WIDTH  to register file read address 1.
rf_raddr2  out  ADDR_WIDTH  to register file read address 2.
rf_rdata1  in  DATA_WIDTH  combinational read data 1.
rf_rdata2  in  DATA_WIDTH  combinational read data 2.

Behaviour:
- Reset, at any point including mid-command: state to IDLE. All outputs are 0 except cmd_ready=1. Pair counter to 0. Any pending response is dropped.
- All outputs are registered. cmd_ready=1 only in IDLE. A command is accepted on the cycle with cmd_valid & cmd_ready (cycle T).
- States: IDLE, WRITE, READ, RSP, DUMP_RD, DUMP_RSP0, DUMP_RSP1, CLEAR.
- Write:
  - T -> WRITE. In T+1: rf_wen=1, rf_waddr=addr, rf_wdata=data.
  - T+2: back in IDLE with rf_wen=0. No response is issued.
  - Writes to index 0 are still issued; the register file discards them.
- Read:
  - T -> READ. In T+1: rf_raddr1=addr; rf_rdata1 is captured at the end of T+1.
  - T+2 -> RSP: rsp_valid=1, rsp_addr=addr, rsp_last=1.
  - Hold until rsp_ready; the handshake cycle returns to IDLE. rsp_* stay stable while stalled.
- Read after write: a read accepted immediately after a write returns the new value.
- Dump:
  - Pair counter k runs 0..N/2-1.
  - DUMP_RD (one cycle): rf_raddr1=2k, rf_raddr2=2k+1; capture both read values.
  - DUMP_RSP0: response for index 2k. On handshake -> DUMP_RSP1: response for index 2k+1.
  - rsp_last=1 only on index N-1.
  - On the DUMP_RSP1 handshake: if k=N/2-1 -> IDLE, else k+1 -> DUMP_RD.
  - Responses are in strict ascending index order, with no gaps or duplicates under arbitrary rsp_ready stalls.
  - N=2 (ADDR_WIDTH=1) gives exactly one pair.
- rf_raddr1/rf_raddr2 are 0 outside READ and DUMP_RD.
- rf_wen is 1 only in WRITE and CLEAR.

Optional Feature:
Macro REG_CLEAR_EN.
- With it: op 11 enters CLEAR.
  - Writes 0 to indices 1..N-1, one per cycle, ascending (N-1 cycles of rf_wen=1).
  - Then one response: rsp_addr=0, rsp_data=0, rsp_last=1.
  - Then IDLE.
- Without it: op 11 is accepted and discarded. No rf activity, no response; cmd_ready returns to 1 the next cycle.

Decomposition:
- Shared package reg_access_pkg holds:
  - op-code constants OP_READ, OP_WRITE, OP_DUMP, OP_CLEAR;
  - state-encoding constants;
  - default DATA_WIDTH/ADDR_WIDTH.
- No sub-module. It is a single FSM plus capture registers; the register file stays a separate instance in the bench and system.

Test Plan:
1. Write 0xA5A5_0001 to reg 3, then read reg 3 -> response addr 3, data 0xA5A5_0001, last=1 at T+2 of the read.
2. Write 0xFFFF_FFFF to reg 0, read reg 0 -> data 0x0000_0000; the write cycle shows rf_wen=1, rf_waddr=0.
3. Load reg i = 0x100+i for i=1..31, dump with rsp_ready toggling 1-0-0-1 -> 32 responses, addr 0..31 ascending, data 0 then 0x101..0x11F, last only at addr 31.
4. Assert rst during DUMP_RSP1 of pair 5 -> next cycle rsp_valid=0, cmd_ready=1; a new read of reg 7 returns 0x107.
5. Hold rsp_ready=0 for 10 cycles on a read of reg 9 -> rsp_valid, rsp_addr and rsp_data stable; cmd_ready=0 throughout.
6. REG_CLEAR_EN defined: clear after load -> 31 write cycles, one response addr 0 data 0, then dump returns all zeros. Undefined: op 11 -> no rf_wen, no response, cmd_ready=1 one cycle later.

Source files
------------

// File: rtl/reg_access_pkg.sv
// Shared constants for the register-file access master: op-codes, FSM state
// encoding and default widths.
package reg_access_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_DUMP  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WRITE     = 3'd1;
  localparam logic [2:0] S_READ      = 3'd2;
  localparam logic [2:0] S_RSP       = 3'd3;
  localparam logic [2:0] S_DUMP_RD   = 3'd4;
  localparam logic [2:0] S_DUMP_RSP0 = 3'd5;
  localparam logic [2:0] S_DUMP_RSP1 = 3'd6;
  localparam logic [2:0] S_CLEAR     = 3'd7;

endpackage

// File: rtl/reg_access_master.sv
// Host-side master for a 1W/2R register file: single/dump reads, writes and
// (with REG_CLEAR_EN defined) a bulk clear. Every output is registered.
module reg_access_master
  import reg_access_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_last,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic                  rf_wen,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic [ADDR_WIDTH-1:0] rf_raddr1,
  output logic [ADDR_WIDTH-1:0] rf_raddr2,
  input  logic [DATA_WIDTH-1:0] rf_rdata1,
  input  logic [DATA_WIDTH-1:0] rf_rdata2
);

  localparam logic [ADDR_WIDTH-1:0] PAIR_LAST = ADDR_WIDTH'((1 << ADDR_WIDTH) / 2 - 1);

  logic [2:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_pair;
  logic [DATA_WIDTH-1:0] r_hi;
  logic [ADDR_WIDTH-1:0] w_even;
  logic [ADDR_WIDTH-1:0] w_odd;

  assign w_even = r_pair << 1;
  assign w_odd  = w_even + ADDR_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_pair    <= '0;
      r_hi      <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_addr  <= '0;
      rsp_data  <= '0;
      rsp_last  <= 1'b0;
      rf_waddr  <= '0;
      rf_wen    <= 1'b0;
      rf_wdata  <= '0;
      rf_raddr1 <= '0;
      rf_raddr2 <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (cmd_valid) begin
          case (cmd_op)
            OP_WRITE: begin
              r_state   <= S_WRITE;
              cmd_ready <= 1'b0;
              rf_wen    <= 1'b1;
              rf_waddr  <= cmd_addr;
              rf_wdata  <= cmd_wdata;
            end
            OP_READ: begin
              r_state   <= S_READ;
              cmd_ready <= 1'b0;
              r_addr    <= cmd_addr;
              rf_raddr1 <= cmd_addr;
            end
            OP_DUMP: begin
              r_state   <= S_DUMP_RD;
              cmd_ready <= 1'b0;
              r_pair    <= '0;
              rf_raddr1 <= '0;
              rf_raddr2 <= ADDR_WIDTH'(1);
            end
            default: begin
`ifdef REG_CLEAR_EN
              // Index 0 is hard-wired in the register file, so start at 1.
              r_state   <= S_CLEAR;
              cmd_ready <= 1'b0;
              rf_wen    <= 1'b1;
              rf_waddr  <= ADDR_WIDTH'(1);
              rf_wdata  <= '0;
`endif
            end
          endcase
        end
        S_WRITE: begin
          r_state   <= S_IDLE;
          cmd_ready <= 1'b1;
          rf_wen    <= 1'b0;
          rf_waddr  <= '0;
          rf_wdata  <= '0;
        end
        S_READ: begin
          r_state   <= S_RSP;
          rsp_valid <= 1'b1;
          rsp_addr  <= r_addr;
          rsp_data  <= rf_rdata1;
          rsp_last  <= 1'b1;
          rf_raddr1 <= '0;
        end
        S_RSP: if (rsp_ready) begin
          r_state   <= S_IDLE;
          cmd_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_addr  <= '0;
          rsp_data  <= '0;
          rsp_last  <= 1'b0;
        end
        S_DUMP_RD: begin
          // Both halves of the pair are captured now; the odd one waits in r_hi.
          r_state   <= S_DUMP_RSP0;
          rsp_valid <= 1'b1;
          rsp_addr  <= w_even;
          rsp_data  <= rf_rdata1;
          rsp_last  <= 1'b0;
          r_hi      <= rf_rdata2;
          rf_raddr1 <= '0;
          rf_raddr2 <= '0;
        end
        S_DUMP_RSP0: if (rsp_ready) begin
          r_state  <= S_DUMP_RSP1;
          rsp_addr <= w_odd;
          rsp_data <= r_hi;
          rsp_last <= (r_pair == PAIR_LAST);
        end
        S_DUMP_RSP1: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          rsp_addr  <= '0;
          rsp_data  <= '0;
          rsp_last  <= 1'b0;
          if (r_pair == PAIR_LAST) begin
            r_state   <= S_IDLE;
            cmd_ready <= 1'b1;
            r_pair    <= '0;
          end else begin
            r_state   <= S_DUMP_RD;
            r_pair    <= r_pair + ADDR_WIDTH'(1);
            rf_raddr1 <= w_even + ADDR_WIDTH'(2);
            rf_raddr2 <= w_odd + ADDR_WIDTH'(2);
          end
        end
`ifdef REG_CLEAR_EN
        S_CLEAR: begin
          if (rf_waddr == '1) begin
            r_state   <= S_RSP;
            rf_wen    <= 1'b0;
            rf_waddr  <= '0;
            rsp_valid <= 1'b1;
            rsp_addr  <= '0;
            rsp_data  <= '0;
            rsp_last  <= 1'b1;
          end else begin
            rf_waddr <= rf_waddr + ADDR_WIDTH'(1);
          end
        end
`endif
        default: begin
          r_state   <= S_IDLE;
          cmd_ready <= 1'b1;
          rf_wen    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_access_master.sv
// Bench for reg_access_master with a behavioural register file and an
// array-based reference of the expected register contents.
module tb_reg_access_master;
  import reg_access_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N  = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_last;
  logic [AW-1:0] rsp_addr;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] rf_waddr, rf_raddr1, rf_raddr2;
  logic          rf_wen;
  logic [DW-1:0] rf_wdata, rf_rdata1, rf_rdata2;

  logic [DW-1:0] rf_mem [N];
  logic [DW-1:0] mdl [N];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_access_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
    .rsp_data(rsp_data), .rsp_last(rsp_last),
    .rf_waddr(rf_waddr), .rf_wen(rf_wen), .rf_wdata(rf_wdata),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2)
  );

  // Register file: index 0 reads zero and ignores writes.
  always @(posedge clk) if (rf_wen && rf_waddr != 0) rf_mem[rf_waddr] <= rf_wdata;
  assign rf_rdata1 = (rf_raddr1 == 0) ? '0 : rf_mem[rf_raddr1];
  assign rf_rdata2 = (rf_raddr2 == 0) ? '0 : rf_mem[rf_raddr2];

  task automatic do_cmd(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL cmd_accept_timeout ready=%b", cmd_ready); end
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = d;
    @(posedge clk); #1 cmd_valid = 1'b0;
    if (op == OP_WRITE && a != 0) mdl[a] = d;
  endtask

  task automatic get_rsp(input int stall, output logic [AW-1:0] a, output logic [DW-1:0] d, output logic l);
    int n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rsp_timeout valid=%b", rsp_valid); end
    repeat (stall) @(negedge clk);
    a = rsp_addr; d = rsp_data; l = rsp_last;
    rsp_ready = 1'b1;
    @(posedge clk); #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid, rsp_last, rf_wen} !== 4'b1000) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=1000", {cmd_ready, rsp_valid, rsp_last, rf_wen});
    end
    checks++;
    if ({rsp_addr, rsp_data, rf_waddr, rf_wdata, rf_raddr1, rf_raddr2} !== '0) begin
      errors++; $display("FAIL reset_data rsp_addr=%0d rsp_data=%h raddr1=%0d raddr2=%0d",
                         rsp_addr, rsp_data, rf_raddr1, rf_raddr2);
    end
    rst = 1'b0;
  endtask

  task automatic test_write_read;
    logic [AW-1:0] a; logic [DW-1:0] d; logic l;
    do_cmd(OP_WRITE, 5'd3, 32'hA5A5_0001);
    @(negedge clk);
    checks++;
    if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'hA5A5_0001}) begin
      errors++; $display("FAIL write_pins wen=%b waddr=%0d wdata=%h exp 1/3/a5a50001", rf_wen, rf_waddr, rf_wdata);
    end
    @(negedge clk);
    checks++;
    if ({rf_wen, cmd_ready} !== 2'b01) begin
      errors++; $display("FAIL write_done wen=%b ready=%b exp 0/1", rf_wen, cmd_ready);
    end
    do_cmd(OP_READ, 5'd3, '0);
    @(negedge clk);
    checks++;
    if ({rf_raddr1, rsp_valid} !== {5'd3, 1'b0}) begin
      errors++; $display("FAIL read_addr raddr1=%0d valid=%b exp 3/0", rf_raddr1, rsp_valid);
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_addr, rsp_data, rsp_last} !== {1'b1, 5'd3, mdl[3], 1'b1}) begin
      errors++; $display("FAIL read_rsp_t2 valid=%b addr=%0d data=%h last=%b exp 1/3/%h/1",
                         rsp_valid, rsp_addr, rsp_data, rsp_last, mdl[3]);
    end
    rsp_ready = 1'b1; @(posedge clk); #1 rsp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      errors++; $display("FAIL read_done ready=%b valid=%b exp 1/0", cmd_ready, rsp_valid);
    end
    do_cmd(OP_WRITE, 5'd0, 32'hFFFF_FFFF);
    @(negedge clk);
    checks++;
    if ({rf_wen, rf_waddr} !== {1'b1, 5'd0}) begin
      errors++; $display("FAIL write_r0 wen=%b waddr=%0d exp 1/0", rf_wen, rf_waddr);
    end
    do_cmd(OP_READ, 5'd0, '0);
    get_rsp(0, a, d, l);
    checks++;
    if ({a, d, l} !== {5'd0, 32'h0, 1'b1}) begin
      errors++; $display("FAIL read_r0 addr=%0d data=%h last=%b exp 0/0/1", a, d, l);
    end
  endtask

  task automatic test_random;
    logic [AW-1:0] a, ra; logic [DW-1:0] d, rd; logic l;
    for (int i = 0; i < 40; i++) begin
      a = AW'($urandom_range(0, N-1));
      d = $urandom;
      if ($urandom_range(0, 1) == 1) do_cmd(OP_WRITE, a, d);
      else begin
        do_cmd(OP_READ, a, '0);
        get_rsp(int'($urandom_range(0, 3)), ra, rd, l);
        checks++;
        if ({ra, rd, l} !== {a, mdl[a], 1'b1}) begin
          errors++; $display("FAIL rand_read addr=%0d data=%h last=%b exp %0d/%h/1", ra, rd, l, a, mdl[a]);
        end
      end
    end
  endtask

  task automatic test_dump(input bit toggle);
    int cnt = 0;
    int cyc = 0;
    do_cmd(OP_DUMP, '0, '0);
    while (cnt < N && cyc < 2000) begin
      @(negedge clk);
      rsp_ready = toggle ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
      cyc++;
      if (rsp_valid && rsp_ready) begin
        checks++;
        if ({rsp_addr, rsp_data, rsp_last} !== {AW'(cnt), mdl[cnt], cnt == N-1}) begin
          errors++; $display("FAIL dump_rsp addr=%0d data=%h last=%b exp %0d/%h/%b",
                             rsp_addr, rsp_data, rsp_last, cnt, mdl[cnt], cnt == N-1);
        end
        cnt++;
      end
    end
    @(posedge clk); #1 rsp_ready = 1'b0;
    checks++;
    if (cnt != N) begin errors++; $display("FAIL dump_count got=%0d exp=%0d", cnt, N); end
    @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      errors++; $display("FAIL dump_done ready=%b valid=%b exp 1/0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_load;
    for (int i = 1; i < N; i++) do_cmd(OP_WRITE, AW'(i), 32'h100 + i);
  endtask

  task automatic test_stall;
    logic [AW-1:0] a0; logic [DW-1:0] d0;
    int n = 0;
    do_cmd(OP_READ, 5'd9, '0);
    @(negedge clk);
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    a0 = rsp_addr; d0 = rsp_data;
    checks++;
    if ({rsp_valid, a0, d0} !== {1'b1, 5'd9, mdl[9]}) begin
      errors++; $display("FAIL stall_first valid=%b addr=%0d data=%h exp 1/9/%h", rsp_valid, a0, d0, mdl[9]);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_addr, rsp_data, cmd_ready} !== {1'b1, a0, d0, 1'b0}) begin
        errors++; $display("FAIL stall_hold cyc=%0d valid=%b addr=%0d data=%h ready=%b",
                           i, rsp_valid, rsp_addr, rsp_data, cmd_ready);
      end
    end
    rsp_ready = 1'b1; @(posedge clk); #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [AW-1:0] a; logic [DW-1:0] d; logic l;
    int n = 0;
    do_cmd(OP_DUMP, '0, '0);
    rsp_ready = 1'b1;
    @(negedge clk);
    while (!(rsp_valid && rsp_addr == 5'd11) && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (rsp_addr !== 5'd11) begin errors++; $display("FAIL midreset_reach addr=%0d exp 11", rsp_addr); end
    rst = 1'b1; rsp_ready = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({rsp_valid, cmd_ready, rf_raddr1, rf_raddr2} !== {1'b0, 1'b1, 5'd0, 5'd0}) begin
      errors++; $display("FAIL midreset_state valid=%b ready=%b raddr1=%0d raddr2=%0d exp 0/1/0/0",
                         rsp_valid, cmd_ready, rf_raddr1, rf_raddr2);
    end
    do_cmd(OP_READ, 5'd7, '0);
    get_rsp(0, a, d, l);
    checks++;
    if ({a, d, l} !== {5'd7, 32'h107, 1'b1}) begin
      errors++; $display("FAIL midreset_read addr=%0d data=%h last=%b exp 7/107/1", a, d, l);
    end
  endtask

  task automatic test_clear;
`ifdef REG_CLEAR_EN
    int cnt = 0;
    int cyc = 0;
    do_cmd(OP_CLEAR, '0, '0);
    @(negedge clk);
    while (!rsp_valid && cyc < 200) begin
      if (rf_wen) begin
        checks++;
        if ({rf_waddr, rf_wdata} !== {AW'(cnt + 1), 32'h0}) begin
          errors++; $display("FAIL clear_write waddr=%0d wdata=%h exp %0d/0", rf_waddr, rf_wdata, cnt + 1);
        end
        cnt++;
      end
      @(negedge clk); cyc++;
    end
    checks++;
    if (cnt != N - 1) begin errors++; $display("FAIL clear_count got=%0d exp=%0d", cnt, N - 1); end
    checks++;
    if ({rsp_valid, rsp_addr, rsp_data, rsp_last} !== {1'b1, 5'd0, 32'h0, 1'b1}) begin
      errors++; $display("FAIL clear_rsp valid=%b addr=%0d data=%h last=%b exp 1/0/0/1",
                         rsp_valid, rsp_addr, rsp_data, rsp_last);
    end
    rsp_ready = 1'b1; @(posedge clk); #1 rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) mdl[i] = '0;
    test_dump(1'b0);
`else
    do_cmd(OP_CLEAR, '0, '0);
    @(negedge clk);
    checks++;
    if ({cmd_ready, rf_wen, rsp_valid} !== 3'b100) begin
      errors++; $display("FAIL clear_off ready=%b wen=%b valid=%b exp 1/0/0", cmd_ready, rf_wen, rsp_valid);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({rf_wen, rsp_valid} !== 2'b00) begin
        errors++; $display("FAIL clear_off_quiet wen=%b valid=%b exp 0/0", rf_wen, rsp_valid);
      end
    end
    test_dump(1'b0);
`endif
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin rf_mem[i] = '0; mdl[i] = '0; end
    test_reset;
    test_write_read;
    test_random;
    test_load;
    test_dump(1'b1);
    test_stall;
    test_reset_mid;
    test_clear;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
